// File: rtl/led7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// One digit is driven per scan slot. Each slot opens with a short all-anodes-off
// gap to prevent ghosting. Display data is double-buffered: load writes a shadow
// copy, and that copy moves to the active copy only when the last digit's slot
// wraps back to digit 0.
module led7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      hex_mode,
    input  logic                      lz_blank,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg;
    logic [IDX_W-1:0]          idx_reg;
    logic [4*NUM_DIGITS-1:0]   shadow_data_reg, active_data_reg;
    logic [NUM_DIGITS-1:0]     shadow_dp_reg, active_dp_reg;
    logic [6:0]                seg_reg, seg_next;
    logic                      dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]     an_reg, an_next;
    logic                      frame_done_reg;

    logic                      slot_end;
    logic                      frame_end;
    logic [3:0]                digit_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     an_sel;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_lz;

    // Active-low {g,f,e,d,c,b,a} patterns; BCD codes 10-15 stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic hex);
        logic [6:0] pat;
        pat = 7'h7F;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = hex ? 7'h08 : 7'h7F;
            4'hB: pat = hex ? 7'h03 : 7'h7F;
            4'hC: pat = hex ? 7'h46 : 7'h7F;
            4'hD: pat = hex ? 7'h21 : 7'h7F;
            4'hE: pat = hex ? 7'h06 : 7'h7F;
            4'hF: pat = hex ? 7'h0E : 7'h7F;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    assign slot_end  = en && (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    // Split the active word into per-digit nibbles and per-digit anode selects.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_nib[gi] = active_data_reg[gi*4 +: 4];
            assign an_sel[gi]    = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Leading-zero mask: digit k>0 is blanked when it and every digit above it are zero.
    always_comb begin
        logic all_zero;
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero && (digit_nib[i] == 4'd0);
            lz_mask[i] = all_zero;
        end
    end

    // Slot counter and digit index; both freeze while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (en) begin
            if (slot_end) begin
                cnt_reg <= '0;
                idx_reg <= frame_end ? '0 : idx_reg + IDX_W'(1);
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Shadow capture on load. At a frame wrap, the active copy takes the pre-edge shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
            active_data_reg <= '0;
            active_dp_reg   <= '0;
        end else begin
            if (load) begin
                shadow_data_reg <= data_in;
                shadow_dp_reg   <= dp_in;
            end
            if (frame_end) begin
                active_data_reg <= shadow_data_reg;
                active_dp_reg   <= shadow_dp_reg;
            end
        end
    end

    // Slot phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BLANK;
        end else begin
            state_reg <= state_next;
        end
    end

    // Phase transitions: the blanking gap ends after BLANK_CYC counts; a slot wrap re-enters the gap.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BLANK: if (en && (cnt_reg == CNT_BLANK_LAST)) state_next = ST_DRIVE;
            ST_DRIVE: if (slot_end) state_next = ST_BLANK;
            default:  state_next = ST_BLANK;
        endcase
    end

    // Select the current digit and build next pin values; dark unless running in DRIVE.
    always_comb begin
        cur_nib = 4'd0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_sel[i]) begin
                cur_nib = digit_nib[i];
                cur_dp  = active_dp_reg[i];
                cur_lz  = lz_mask[i];
            end
        end
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        an_next  = '1;
        if (en && (state_reg == ST_DRIVE)) begin
            an_next  = ~an_sel;
            seg_next = (lz_blank && cur_lz) ? 7'h7F : seg_decode(cur_nib, hex_mode);
            dp_next  = ~cur_dp;
        end
    end

    // Registered pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            frame_done_reg <= frame_end;
        end
    end

    assign seg_out    = seg_reg;
    assign dp_out     = dp_reg;
    assign an_out     = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_led7_scan_driver.sv
// Directed testbench for led7_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
module tb_led7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        hex_mode;
    logic        lz_blank;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-frame capture results, indexed by digit.
    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];
    int         cap_lit [4];
    int         cap_dark;
    int         cap_bad;
    int         cap_torn;

    led7_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BLANK_CYC  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .hex_mode   (hex_mode),
        .lz_blank   (lz_blank),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(posedge clk); #1;
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        @(posedge clk); #1;
        load    = 1'b0;
    endtask

    // Returns at the negedge where frame_done is high; a timeout counts as a failure.
    task automatic wait_frame_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL frame_done_wait: got no pulse in 64 cycles, required one");
        end
    endtask

    // Samples one full frame (16 cycles) of pins, optionally waiting for frame_done first.
    task automatic capture_frame(input bit wait_fd);
        int d;
        if (wait_fd) wait_frame_done();
        for (int i = 0; i < 4; i++) begin
            cap_seg[i] = 7'h7F;
            cap_dp[i]  = 1'b1;
            cap_lit[i] = 0;
        end
        cap_dark = 0;
        cap_bad  = 0;
        cap_torn = 0;
        repeat (16) begin
            @(negedge clk);
            if (an_out === 4'hF) begin
                cap_dark++;
            end else begin
                d = -1;
                for (int i = 0; i < 4; i++)
                    if (an_out[i] === 1'b0 && $countones(an_out) == 3) d = i;
                if (d < 0) begin
                    cap_bad++;
                end else begin
                    if (cap_lit[d] == 0) begin
                        cap_seg[d] = seg_out;
                        cap_dp[d]  = dp_out;
                    end else if (cap_seg[d] !== seg_out || cap_dp[d] !== dp_out) begin
                        cap_torn++;
                    end
                    cap_lit[d]++;
                end
            end
        end
        $display("frame: seg d3..d0 = %h %h %h %h  dp d3..d0 = %b%b%b%b  dark=%0d",
                 cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0],
                 cap_dp[3], cap_dp[2], cap_dp[1], cap_dp[0], cap_dark);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        en       = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        dp_in    = '0;
        hex_mode = 1'b0;
        lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", seg_out); end
        n_checks++; if (dp_out !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp_out); end
        n_checks++; if (an_out !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h expected f", an_out); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (an_out !== 4'hF) begin n_fail++; $display("FAIL release_blank_an: got %h expected f", an_out); end
        @(posedge clk); #1;
        n_checks++; if (an_out !== 4'hE) begin n_fail++; $display("FAIL release_first_an: got %h expected e", an_out); end
        n_checks++; if (seg_out !== 7'h40) begin n_fail++; $display("FAIL release_first_seg: got %h expected 40", seg_out); end
        $display("reset: seg=%h dp=%b an=%h", seg_out, dp_out, an_out);
    endtask

    task automatic test_digits();
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        hex_mode = 1'b0;
        lz_blank = 1'b0;
        do_load(16'h1234, 4'b0100);
        wait_frame_done();
        capture_frame(1'b1);
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_seg[i]) begin n_fail++; $display("FAIL digits_seg%0d: got %h expected %h", i, cap_seg[i], exp_seg[i]); end
            n_checks++; if (cap_dp[i] !== exp_dp[i]) begin n_fail++; $display("FAIL digits_dp%0d: got %b expected %b", i, cap_dp[i], exp_dp[i]); end
            n_checks++; if (cap_lit[i] != 3) begin n_fail++; $display("FAIL digits_lit%0d: got %0d expected 3", i, cap_lit[i]); end
        end
        n_checks++; if (cap_dark != 4) begin n_fail++; $display("FAIL digits_dark: got %0d expected 4", cap_dark); end
        n_checks++; if (cap_bad != 0) begin n_fail++; $display("FAIL digits_onehot: got %0d bad anode samples expected 0", cap_bad); end
    endtask

    task automatic test_hex();
        logic [6:0] exp_bcd [4];
        logic [6:0] exp_hex [4];
        hex_mode = 1'b0;
        lz_blank = 1'b0;
        do_load(16'h00AF, 4'b0000);
        wait_frame_done();
        capture_frame(1'b1);
        exp_bcd = '{7'h7F, 7'h7F, 7'h40, 7'h40};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_bcd[i]) begin n_fail++; $display("FAIL bcd_seg%0d: got %h expected %h", i, cap_seg[i], exp_bcd[i]); end
        end
        hex_mode = 1'b1;
        capture_frame(1'b1);
        exp_hex = '{7'h0E, 7'h08, 7'h40, 7'h40};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_hex[i]) begin n_fail++; $display("FAIL hex_seg%0d: got %h expected %h", i, cap_seg[i], exp_hex[i]); end
        end
        hex_mode = 1'b0;
    endtask

    task automatic test_lz_blank();
        logic [6:0] exp_a [4];
        logic [6:0] exp_b [4];
        lz_blank = 1'b1;
        do_load(16'h0050, 4'b0000);
        wait_frame_done();
        capture_frame(1'b1);
        exp_a = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_a[i]) begin n_fail++; $display("FAIL lz50_seg%0d: got %h expected %h", i, cap_seg[i], exp_a[i]); end
        end
        do_load(16'h0000, 4'b1000);
        wait_frame_done();
        capture_frame(1'b1);
        exp_b = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_b[i]) begin n_fail++; $display("FAIL lz00_seg%0d: got %h expected %h", i, cap_seg[i], exp_b[i]); end
        end
        n_checks++; if (cap_dp[3] !== 1'b0) begin n_fail++; $display("FAIL lz_dp3: got %b expected 0", cap_dp[3]); end
        n_checks++; if (cap_lit[3] != 3) begin n_fail++; $display("FAIL lz_anode3_pulses: got %0d expected 3", cap_lit[3]); end
        lz_blank = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_old [4];
        logic [6:0] exp_new [4];
        do_load(16'h5678, 4'b0000);
        wait_frame_done();
        wait_frame_done();
        // Next wrap edge is 16 edges after the frame_done just seen; strobe load on it.
        repeat (15) @(posedge clk);
        #1;
        data_in = 16'h1111;
        dp_in   = 4'b1111;
        load    = 1'b1;
        fork
            capture_frame(1'b1);
            begin
                @(posedge clk); #1;
                load = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                data_in = 16'h8421;
                dp_in   = 4'b0001;
                load    = 1'b1;
                @(posedge clk); #1;
                load    = 1'b0;
            end
        join
        exp_old = '{7'h00, 7'h78, 7'h02, 7'h12};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_old[i]) begin n_fail++; $display("FAIL b2b_old_seg%0d: got %h expected %h", i, cap_seg[i], exp_old[i]); end
        end
        n_checks++; if (cap_torn != 0) begin n_fail++; $display("FAIL b2b_torn: got %0d changes within a slot expected 0", cap_torn); end
        capture_frame(1'b0);
        exp_new = '{7'h79, 7'h24, 7'h19, 7'h00};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_seg[i] !== exp_new[i]) begin n_fail++; $display("FAIL b2b_new_seg%0d: got %h expected %h", i, cap_seg[i], exp_new[i]); end
        end
        n_checks++; if (cap_dp[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_new_dp0: got %b expected 0", cap_dp[0]); end
    endtask

    task automatic test_enable_pause();
        logic [3:0] prev_an;
        bit         found;
        int         dark_bad;
        int         fd_seen;
        prev_an = 4'h0;
        found   = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (prev_an === 4'hF && an_out === 4'hD) found = 1'b1;
            prev_an = an_out;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL pause_find_slot1: got no digit1 slot start expected one"); end
        en       = 1'b0;
        dark_bad = 0;
        fd_seen  = 0;
        repeat (10) begin
            @(negedge clk);
            if (an_out !== 4'hF || seg_out !== 7'h7F || dp_out !== 1'b1) dark_bad++;
            if (frame_done !== 1'b0) fd_seen++;
        end
        n_checks++; if (dark_bad != 0) begin n_fail++; $display("FAIL pause_dark: got %0d lit samples expected 0", dark_bad); end
        n_checks++; if (fd_seen != 0) begin n_fail++; $display("FAIL pause_frame_done: got %0d pulses expected 0", fd_seen); end
        en = 1'b1;
        @(negedge clk);
        n_checks++; if (an_out !== 4'hD) begin n_fail++; $display("FAIL resume_an_a: got %h expected d", an_out); end
        n_checks++; if (seg_out !== 7'h24) begin n_fail++; $display("FAIL resume_seg: got %h expected 24", seg_out); end
        @(negedge clk);
        n_checks++; if (an_out !== 4'hD) begin n_fail++; $display("FAIL resume_an_b: got %h expected d", an_out); end
        @(negedge clk);
        n_checks++; if (an_out !== 4'hF) begin n_fail++; $display("FAIL resume_gap: got %h expected f", an_out); end
        @(negedge clk);
        n_checks++; if (an_out !== 4'hB) begin n_fail++; $display("FAIL resume_next_digit: got %h expected b", an_out); end
        $display("pause: dark_bad=%0d frame_done_seen=%0d resumed an=%h", dark_bad, fd_seen, an_out);
    endtask

    task automatic test_reset_mid_scan();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (an_out === 4'hE) found = 1'b1;
        end
        n_checks++; if (!found || dp_out !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_dp: got an=%h dp=%b expected an=e dp=0", an_out, dp_out); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL midrst_seg: got %h expected 7f", seg_out); end
        n_checks++; if (dp_out !== 1'b1) begin n_fail++; $display("FAIL midrst_dp: got %b expected 1", dp_out); end
        n_checks++; if (an_out !== 4'hF) begin n_fail++; $display("FAIL midrst_an: got %h expected f", an_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (an_out !== 4'hF) begin n_fail++; $display("FAIL midrst_release_blank: got %h expected f", an_out); end
        @(posedge clk); #1;
        n_checks++; if (an_out !== 4'hE) begin n_fail++; $display("FAIL midrst_release_an: got %h expected e", an_out); end
        n_checks++; if (seg_out !== 7'h40) begin n_fail++; $display("FAIL midrst_release_seg: got %h expected 40", seg_out); end
        n_checks++; if (dp_out !== 1'b1) begin n_fail++; $display("FAIL midrst_release_dp: got %b expected 1", dp_out); end
        $display("mid-scan reset: an=%h seg=%h dp=%b", an_out, seg_out, dp_out);
    endtask

    initial begin
        test_reset();
        test_digits();
        test_hex();
        test_lz_blank();
        test_back_to_back();
        test_enable_pause();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
